// File: rtl/mmu_tlb.sv
// mmu_tlb: fully-associative joint TLB beside CP0 (TLBWI/TLBWR/TLBR/TLBP, 1-cycle translation).
// Define TLB_MULTIHIT_EN to add tlb_machine_check_o, flagging lookups that match several entries.
module mmu_tlb #(
   parameter int unsigned INDEX_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cpu_pause_i,
   input  logic                   instr_TLBWI_i,
   input  logic                   instr_TLBWR_i,
   input  logic                   instr_TLBR_i,
   input  logic                   instr_TLBP_i,
   input  logic [31:0]            cp0_index_i,
   input  logic [31:0]            cp0_random_i,
   input  logic                   cp0_status_um_i,
   input  logic [31:0]            cp0_entryhi_i,
   input  logic [31:0]            cp0_entrylo0_i,
   input  logic [31:0]            cp0_entrylo1_i,
   output logic [31:0]            cp0_entryhi_o,
   output logic [31:0]            cp0_entrylo0_o,
   output logic [31:0]            cp0_entrylo1_o,
   output logic                   cp0_entryhi_wen_o,
   output logic                   cp0_entrylo0_wen_o,
   output logic                   cp0_entrylo1_wen_o,
   output logic                   tlb_probe_success_o,
   output logic [INDEX_WIDTH-1:0] tlb_probe_index_o,
   input  logic                   req_i,
   input  logic                   rw_i,
   input  logic [31:0]            vaddr_i,
   output logic [31:0]            paddr_o,
   output logic                   exception_addr_error_o,
   output logic                   exception_tlb_refill_o,
   output logic                   exception_tlb_invalid_o,
   output logic                   exception_tlb_mod_o,
   output logic                   exception_tlb_rw_o
`ifdef TLB_MULTIHIT_EN
   ,
   output logic                   tlb_machine_check_o
`endif
);

   localparam int unsigned Entries = 2 ** INDEX_WIDTH;

   typedef struct packed {
      logic [19:0] pfn;
      logic [2:0]  c;
      logic        d;
      logic        v;
   } page_t;

   typedef struct packed {
      logic [18:0]     vpn2;
      logic [7:0]      asid;
      logic            g;
      page_t [1:0]     pg;
   } entry_t;

   entry_t                 entries_q [Entries];
   logic [Entries-1:0]     used_q, used_d;

   logic [31:0]            paddr_q, paddr_d;
   logic                   ae_q, ae_d, refill_q, refill_d, inv_q, inv_d, mod_q, mod_d;
   logic                   rw_q, rw_d;
   logic [31:0]            hi_q, hi_d, lo0_q, lo0_d, lo1_q, lo1_d;
   logic                   wen_q, wen_d;
   logic                   ps_q, ps_d;
   logic [INDEX_WIDTH-1:0] pi_q, pi_d;

   logic                   op_wi, op_wr, op_r, op_p, wr_en;
   logic [INDEX_WIDTH-1:0] wr_idx, tr_idx, pr_idx;
   logic [Entries-1:0]     tr_match, pr_match;
   logic                   tr_hit, pr_hit, mapped;
   entry_t                 new_entry, tr_entry, rd_entry;
   page_t                  tr_page;

   // Only one op per cycle, and nothing executes while the pipeline is paused.
   assign op_wi = ~cpu_pause_i & instr_TLBWI_i;
   assign op_wr = ~cpu_pause_i & ~instr_TLBWI_i & instr_TLBWR_i;
   assign op_r  = ~cpu_pause_i & ~instr_TLBWI_i & ~instr_TLBWR_i & instr_TLBR_i;
   assign op_p  = ~cpu_pause_i & ~instr_TLBWI_i & ~instr_TLBWR_i & ~instr_TLBR_i & instr_TLBP_i;
   assign wr_en = op_wi | op_wr;
   assign wr_idx = op_wi ? cp0_index_i[INDEX_WIDTH-1:0] : cp0_random_i[INDEX_WIDTH-1:0];

   always_comb begin
      new_entry       = '0;
      new_entry.vpn2  = cp0_entryhi_i[31:13];
      new_entry.asid  = cp0_entryhi_i[7:0];
      new_entry.g     = cp0_entrylo0_i[0] & cp0_entrylo1_i[0];
      new_entry.pg[0] = page_t'(cp0_entrylo0_i[25:1]);
      new_entry.pg[1] = page_t'(cp0_entrylo1_i[25:1]);
   end

   // Lowest matching index wins for both translation and probe.
   always_comb begin
      tr_match = '0;
      pr_match = '0;
      tr_hit   = 1'b0;
      pr_hit   = 1'b0;
      tr_idx   = '0;
      pr_idx   = '0;
      for (int unsigned i = 0; i < Entries; i++) begin
         tr_match[i] = used_q[i] && (entries_q[i].vpn2 == vaddr_i[31:13]) &&
                       (entries_q[i].g || (entries_q[i].asid == cp0_entryhi_i[7:0]));
         pr_match[i] = used_q[i] && (entries_q[i].vpn2 == cp0_entryhi_i[31:13]) &&
                       (entries_q[i].g || (entries_q[i].asid == cp0_entryhi_i[7:0]));
         if (tr_match[i] && !tr_hit) begin
            tr_hit = 1'b1;
            tr_idx = INDEX_WIDTH'(i);
         end
         if (pr_match[i] && !pr_hit) begin
            pr_hit = 1'b1;
            pr_idx = INDEX_WIDTH'(i);
         end
      end
   end

   assign tr_entry = entries_q[tr_idx];
   assign tr_page  = tr_entry.pg[vaddr_i[12]];
   assign rd_entry = entries_q[cp0_index_i[INDEX_WIDTH-1:0]];
   assign mapped   = !(vaddr_i[31] && cp0_status_um_i) && (vaddr_i[31:30] != 2'b10);

   always_comb begin
      used_d   = used_q;
      paddr_d  = paddr_q;
      ae_d     = 1'b0;
      refill_d = 1'b0;
      inv_d    = 1'b0;
      mod_d    = 1'b0;
      rw_d     = rw_q;
      hi_d     = hi_q;
      lo0_d    = lo0_q;
      lo1_d    = lo1_q;
      wen_d    = op_r;
      ps_d     = ps_q;
      pi_d     = pi_q;

      if (wr_en) begin
         used_d[wr_idx] = 1'b1;
      end

      if (req_i) begin
         rw_d = rw_i;
         if (vaddr_i[31] && cp0_status_um_i) begin
            ae_d    = 1'b1;
            paddr_d = '0;
         end else if (vaddr_i[31:29] == 3'b100) begin
            paddr_d = vaddr_i - 32'h8000_0000;
         end else if (vaddr_i[31:29] == 3'b101) begin
            paddr_d = vaddr_i - 32'hA000_0000;
         end else if (!tr_hit) begin
            refill_d = 1'b1;
         end else if (!tr_page.v) begin
            inv_d = 1'b1;
         end else if (!tr_page.d && rw_i) begin
            mod_d = 1'b1;
         end else begin
            paddr_d = {tr_page.pfn, vaddr_i[11:0]};
         end
      end

      if (op_r) begin
         if (used_q[cp0_index_i[INDEX_WIDTH-1:0]]) begin
            hi_d  = {rd_entry.vpn2, 5'b0, rd_entry.asid};
            lo0_d = {6'b0, rd_entry.pg[0], rd_entry.g};
            lo1_d = {6'b0, rd_entry.pg[1], rd_entry.g};
         end else begin
            hi_d  = '0;
            lo0_d = '0;
            lo1_d = '0;
         end
      end

      if (op_p) begin
         ps_d = pr_hit;
         pi_d = pr_idx;
      end
   end

   // Entry payload is not reset; the used bits alone gate matching.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         entries_q[wr_idx] <= new_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         used_q   <= '0;
         paddr_q  <= '0;
         ae_q     <= 1'b0;
         refill_q <= 1'b0;
         inv_q    <= 1'b0;
         mod_q    <= 1'b0;
         rw_q     <= 1'b0;
         hi_q     <= '0;
         lo0_q    <= '0;
         lo1_q    <= '0;
         wen_q    <= 1'b0;
         ps_q     <= 1'b0;
         pi_q     <= '0;
      end else if (!cpu_pause_i) begin
         used_q   <= used_d;
         paddr_q  <= paddr_d;
         ae_q     <= ae_d;
         refill_q <= refill_d;
         inv_q    <= inv_d;
         mod_q    <= mod_d;
         rw_q     <= rw_d;
         hi_q     <= hi_d;
         lo0_q    <= lo0_d;
         lo1_q    <= lo1_d;
         wen_q    <= wen_d;
         ps_q     <= ps_d;
         pi_q     <= pi_d;
      end
   end

`ifdef TLB_MULTIHIT_EN
   logic mc_q, mc_d;

   always_comb begin
      mc_d = 1'b0;
      if (req_i && mapped && ((tr_match & (tr_match - Entries'(1))) != '0)) begin
         mc_d = 1'b1;
      end
      if (op_p && ((pr_match & (pr_match - Entries'(1))) != '0)) begin
         mc_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mc_q <= 1'b0;
      end else if (!cpu_pause_i) begin
         mc_q <= mc_d;
      end
   end

   assign tlb_machine_check_o = mc_q;
`else
   logic unused_mapped;
   assign unused_mapped = mapped;
`endif

   logic unused_bits;
   assign unused_bits = ^{cp0_index_i[31:INDEX_WIDTH], cp0_random_i[31:INDEX_WIDTH],
                          cp0_entryhi_i[12:8], cp0_entrylo0_i[31:26], cp0_entrylo1_i[31:26]};

   assign paddr_o                 = paddr_q;
   assign exception_addr_error_o  = ae_q;
   assign exception_tlb_refill_o  = refill_q;
   assign exception_tlb_invalid_o = inv_q;
   assign exception_tlb_mod_o     = mod_q;
   assign exception_tlb_rw_o      = rw_q;
   assign cp0_entryhi_o           = hi_q;
   assign cp0_entrylo0_o          = lo0_q;
   assign cp0_entrylo1_o          = lo1_q;
   assign cp0_entryhi_wen_o       = wen_q;
   assign cp0_entrylo0_wen_o      = wen_q;
   assign cp0_entrylo1_wen_o      = wen_q;
   assign tlb_probe_success_o     = ps_q;
   assign tlb_probe_index_o       = pi_q;

endmodule

// File: doc/mmu_tlb.md
Name: mmu_tlb

Overview:
- Fully-associative joint TLB sitting beside CP0.
- Consumes CP0 Index/Random/EntryHi/EntryLo0/EntryLo1 for TLBWI/TLBWR/TLBR/TLBP.
- Returns TLBR/TLBP results to CP0 through its entry write-enable and probe inputs.
- Translates one virtual address per cycle for the memory stage. Raises the refill/invalid/mod/address-error strobes that CP0 consumes as exceptions.

Parameters:
INDEX_WIDTH, 4, index bits; entry count = 2**INDEX_WIDTH (16, matches CP0 Index/Random width)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
cpu_pause_i  in  1  pipeline stall; holds all state and outputs
instr_TLBWI_i  in  1  write entry at cp0_index_i[INDEX_WIDTH-1:0]
instr_TLBWR_i  in  1  write entry at cp0_random_i[INDEX_WIDTH-1:0]
instr_TLBR_i  in  1  read entry at cp0_index_i into CP0
instr_TLBP_i  in  1  probe using cp0_entryhi_i
cp0_index_i  in  32  CP0 Index
cp0_random_i  in  32  CP0 Random
cp0_status_um_i  in  1  user mode
cp0_entryhi_i  in  32  VPN2[31:13], ASID[7:0]
cp0_entrylo0_i  in  32  PFN[25:6], C[5:3], D[2], V[1], G[0] (even page)
cp0_entrylo1_i  in  32  same layout (odd page)
cp0_entryhi_o / cp0_entrylo0_o / cp0_entrylo1_o  out  32  TLBR data to CP0
cp0_entryhi_wen_o / cp0_entrylo0_wen_o / cp0_entrylo1_wen_o  out  1  TLBR write strobes
tlb_probe_success_o  out  1  TLBP hit
tlb_probe_index_o  out  INDEX_WIDTH  hit index on TLBP
req_i  in  1  translation request
rw_i  in  1  1 = store, 0 = load/fetch
vaddr_i  in  32  virtual address
paddr_o  out  32  physical address
exception_addr_error_o, exception_tlb_refill_o, exception_tlb_invalid_o, exception_tlb_mod_o  out  1  exception strobes
exception_tlb_rw_o  out  1  registered copy of rw_i for the faulting access

Behaviour:
- Entry storage: used, VPN2[18:0], ASID[7:0], G, PFN0[19:0], C0[2:0], D0, V0, and the same fields for page 1.
- G is stored as entrylo0.G AND entrylo1.G.
- Reset clears every used bit. Reset also clears all registered outputs to 0, including paddr_o.
- Entries with used=0 never match.
- Match rule: used && VPN2 == addr[31:13] && (G || ASID == cp0_entryhi_i[7:0]).
  - Multiple matches: lowest index wins.
  - Page select is vaddr_i[12].
- Op priority when more than one op is asserted: TLBWI > TLBWR > TLBR > TLBP. Only one op executes per cycle.
- TLBWI/TLBWR: the entry is updated at the clock edge and sets used=1. A translation in the same cycle sees the pre-write contents.
- TLBR: one cycle after the op, *_o carry the entry fields and all three wen_o pulse high for one cycle.
  - entryhi_o = {VPN2, 5'b0, ASID}.
  - entrylo_o = {6'b0, PFN, C, D, V, G}.
  - If the read entry has used=0, all data outputs are 0 and the wens still pulse.
- TLBP: one cycle after the op, tlb_probe_success_o = hit and tlb_probe_index_o = hit index (0 on miss). Both hold until the next TLBP.
- Translation has 1-cycle latency: the outputs at edge N+1 reflect req_i/vaddr_i sampled at edge N.
  - When req_i=0, exception strobes are 0 and paddr_o holds.
- Address decode and response (outputs registered, in priority order):
  - Address error: vaddr_i[31]=1 and cp0_status_um_i=1 → addr_error=1, paddr_o=0.
  - kseg0 (0x8000_0000–0x9FFF_FFFF) → paddr_o = vaddr_i - 0x8000_0000, no TLB lookup.
  - kseg1 (0xA000_0000–0xBFFF_FFFF) → paddr_o = vaddr_i - 0xA000_0000, no TLB lookup.
  - Other mapped space, no match → refill=1.
  - Match with V=0 → invalid=1.
  - Match, V=1, D=0, rw_i=1 → mod=1.
  - Otherwise paddr_o = {PFN[19:0], vaddr_i[11:0]}.
- Exactly one exception strobe may be high per cycle.
- exception_tlb_rw_o = rw_i of the sampled request.
- Pause: no entry writes, no output updates, ops and requests ignored. A wen pulse that was high stays high until the first unpaused edge, then drops.
- Reset mid-operation: a pending TLBR/TLBP result is discarded and outputs return to 0 on the same edge.

Optional Feature:
- Macro: TLB_MULTIHIT_EN.
- Defined: adds output tlb_machine_check_o (1 bit, registered, reset 0). It pulses one cycle after a mapped translation, or a TLBP, that matches two or more entries. Translation still uses the lowest index.
- Undefined: the port and the multi-match logic are absent.

Test Plan:
- TLBWI with index=3, entryhi=0x0040_2005, lo0=0x0000_1046 (PFN 0x41, D=1, V=1, G=0), ASID 0x05; then req vaddr 0x0040_2ABC load → paddr 0x0004_1ABC next cycle, no exceptions.
- Same entry, ASID changed to 0x06 → refill=1. Set G in both lo0 and lo1 and rewrite → hit regardless of ASID.
- lo0 with D=0, V=1, store to even page → mod=1 and exception_tlb_rw_o=1. V=0 load → invalid=1.
- TLBP of the written VPN2/ASID → probe_success=1 and index=3. Probe of an absent VPN2 → success=0 and index=0. TLBR at index 3 → wens pulse one cycle with the written data.
- vaddr 0x8000_1234 → paddr 0x0000_1234. vaddr 0xA000_0010 → paddr 0x0000_0010. vaddr 0x8000_0000 with um=1 → addr_error=1.
- Assert cpu_pause_i for 3 cycles during a TLBR → wens held, no entry change; wens drop after the release edge. Reset after writes → every mapped access refills.
